// File: rtl/axil_shadow_merge_if.sv
// AXI-Lite bus bundle used on both the slave and master sides of axil_shadow_merge.
// The master modport drives a request; the slave modport answers it.
interface axil_shadow_merge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axil_shadow_merge.sv
// AXI-Lite bridge that merges partial-strobe writes into a shadow register file and
// forwards full-word writes downstream when a commit lane is touched.
// Optional macro SHADOW_READ_EN: serve in-range reads from the shadow copy.
module axil_shadow_merge #(
    parameter int                  N_REGS       = 8,
    parameter int                  DATA_W       = 32,
    parameter int                  ADDR_W       = 32,
    parameter logic [DATA_W/8-1:0] COMMIT_LANES = 'b1
) (
    input logic                i_clk,
    input logic                i_reset,
    axil_shadow_merge_if.slave  s_axil,
    axil_shadow_merge_if.master m_axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(N_REGS);
    localparam int WORD_W = ADDR_W - LSB_W;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_WAIT_B, W_RESP} wstate_t;

    wstate_t           r_wstate;
    wstate_t           w_wstate_next;

    logic [DATA_W-1:0] r_shadow [N_REGS];
    logic              r_aw_held;
    logic              r_w_held;
    logic [WORD_W-1:0] r_aw_word;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_pending;
    logic              r_m_awvalid;
    logic              r_m_wvalid;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic              w_awready;
    logic              w_wready;
    logic              w_aw_fire;
    logic              w_w_fire;
    logic              w_decide;
    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_merged;
    logic              w_in_range;
    logic              w_commit;
    logic              w_unused;

    assign w_awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign w_wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign w_aw_fire = s_axil.AWVALID && w_awready;
    assign w_w_fire  = s_axil.WVALID && w_wready;

    // A beat arriving this cycle counts as held, so the decision lands on the accepting edge.
    assign w_word   = r_aw_held ? r_aw_word : s_axil.AWADDR[ADDR_W-1:LSB_W];
    assign w_wdata  = r_w_held ? r_wdata : s_axil.WDATA;
    assign w_wstrb  = r_w_held ? r_wstrb : s_axil.WSTRB;
    assign w_idx    = w_word[IDX_W-1:0];
    assign w_decide = (r_wstate == W_IDLE) && (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);

    always_comb begin
        w_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            w_mask[b*8 +: 8] = {8{w_wstrb[b]}};
        end
    end

    assign w_merged   = (r_shadow[w_idx] & ~w_mask) | (w_wdata & w_mask);
    assign w_in_range = (w_word < WORD_W'(N_REGS));
    assign w_commit   = |(w_wstrb & COMMIT_LANES);

    assign s_axil.AWREADY = w_awready;
    assign s_axil.WREADY  = w_wready;
    assign s_axil.BVALID  = r_bvalid;
    assign s_axil.BRESP   = r_bresp;

    assign m_axi.AWVALID = r_m_awvalid;
    assign m_axi.AWADDR  = ADDR_W'({r_idx, {LSB_W{1'b0}}});
    assign m_axi.WVALID  = r_m_wvalid;
    assign m_axi.WDATA   = r_pending;
    assign m_axi.WSTRB   = '1;
    assign m_axi.BREADY  = (r_wstate == W_WAIT_B);

    assign w_unused = &{1'b0, s_axil.AWADDR[LSB_W-1:0]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
        end
    end

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_decide) begin
                    w_wstate_next = (w_in_range && w_commit) ? W_FWD : W_RESP;
                end
            end
            W_FWD: begin
                if ((!r_m_awvalid || m_axi.AWREADY) && (!r_m_wvalid || m_axi.WREADY)) begin
                    w_wstate_next = W_WAIT_B;
                end
            end
            W_WAIT_B: begin
                if (m_axi.BVALID) begin
                    w_wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil.BREADY) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Shadow is only touched on a local merge or after an OKAY from downstream.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_aw_word   <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_idx       <= '0;
            r_pending   <= '0;
            r_m_awvalid <= 1'b0;
            r_m_wvalid  <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            for (int i = 0; i < N_REGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_aw_word <= s_axil.AWADDR[ADDR_W-1:LSB_W];
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axil.WDATA;
                r_wstrb  <= s_axil.WSTRB;
            end
            case (r_wstate)
                W_IDLE: begin
                    if (w_decide) begin
                        r_idx     <= w_idx;
                        r_pending <= w_merged;
                        if (!w_in_range) begin
                            r_bresp  <= 2'b11;
                            r_bvalid <= 1'b1;
                        end else if (!w_commit) begin
                            r_shadow[w_idx] <= w_merged;
                            r_bresp         <= 2'b00;
                            r_bvalid        <= 1'b1;
                        end else begin
                            r_m_awvalid <= 1'b1;
                            r_m_wvalid  <= 1'b1;
                        end
                    end
                end
                W_FWD: begin
                    if (m_axi.AWREADY) begin
                        r_m_awvalid <= 1'b0;
                    end
                    if (m_axi.WREADY) begin
                        r_m_wvalid <= 1'b0;
                    end
                end
                W_WAIT_B: begin
                    if (m_axi.BVALID) begin
                        r_bresp  <= m_axi.BRESP;
                        r_bvalid <= 1'b1;
                        if (m_axi.BRESP == 2'b00) begin
                            r_shadow[r_idx] <= r_pending;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axil.BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SHADOW_READ_EN
    typedef enum logic [1:0] {R_IDLE, R_LOCAL, R_FWD_AR, R_FWD_R} rstate_t;

    rstate_t           r_rstate;
    rstate_t           w_rstate_next;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_m_arvalid;
    logic [WORD_W-1:0] w_ar_word;
    logic              w_ar_in_range;

    assign w_ar_word     = s_axil.ARADDR[ADDR_W-1:LSB_W];
    assign w_ar_in_range = (w_ar_word < WORD_W'(N_REGS));

    assign s_axil.ARREADY = (r_rstate == R_IDLE);
    assign m_axi.ARVALID  = r_m_arvalid;
    assign m_axi.ARADDR   = r_araddr;
    assign s_axil.RVALID  = (r_rstate == R_LOCAL) || ((r_rstate == R_FWD_R) && m_axi.RVALID);
    assign s_axil.RDATA   = (r_rstate == R_LOCAL) ? r_rdata : m_axi.RDATA;
    assign s_axil.RRESP   = (r_rstate == R_LOCAL) ? 2'b00 : m_axi.RRESP;
    assign m_axi.RREADY   = (r_rstate == R_FWD_R) && s_axil.RREADY;

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (s_axil.ARVALID) begin
                    w_rstate_next = w_ar_in_range ? R_LOCAL : R_FWD_AR;
                end
            end
            R_LOCAL: begin
                if (s_axil.RREADY) begin
                    w_rstate_next = R_IDLE;
                end
            end
            R_FWD_AR: begin
                if (m_axi.ARREADY) begin
                    w_rstate_next = R_FWD_R;
                end
            end
            R_FWD_R: begin
                if (m_axi.RVALID && s_axil.RREADY) begin
                    w_rstate_next = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Out-of-range reads are replayed downstream; the reply is passed straight back.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rstate    <= R_IDLE;
            r_rdata     <= '0;
            r_araddr    <= '0;
            r_m_arvalid <= 1'b0;
        end else begin
            r_rstate <= w_rstate_next;
            if ((r_rstate == R_IDLE) && s_axil.ARVALID) begin
                if (w_ar_in_range) begin
                    r_rdata <= r_shadow[w_ar_word[IDX_W-1:0]];
                end else begin
                    r_araddr    <= s_axil.ARADDR;
                    r_m_arvalid <= 1'b1;
                end
            end
            if ((r_rstate == R_FWD_AR) && m_axi.ARREADY) begin
                r_m_arvalid <= 1'b0;
            end
        end
    end
`else
    assign m_axi.ARVALID  = s_axil.ARVALID;
    assign m_axi.ARADDR   = s_axil.ARADDR;
    assign s_axil.ARREADY = m_axi.ARREADY;
    assign s_axil.RVALID  = m_axi.RVALID;
    assign s_axil.RDATA   = m_axi.RDATA;
    assign s_axil.RRESP   = m_axi.RRESP;
    assign m_axi.RREADY   = s_axil.RREADY;
`endif
endmodule
